// File: rtl/sc_movescheduler_pkg.sv
// sc_movescheduler shared types
// States, command codes, shift codes, button/flag indices
package sc_movescheduler_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_INIT,
    S_RUN,
    S_ISSUE,
    S_SETTLE,
    S_PAUSE
  } state_t;

  typedef enum logic [2:0] {
    CMD_NONE,
    CMD_UP,
    CMD_DOWN,
    CMD_LEFT,
    CMD_RIGHT
  } cmd_t;

  localparam logic [1:0] SHIFT_HOLD  = 2'b11;
  localparam logic [1:0] SHIFT_LEFT  = 2'b01;
  localparam logic [1:0] SHIFT_RIGHT = 2'b10;

  localparam int B_START = 0;
  localparam int B_UP    = 1;
  localparam int B_DOWN  = 2;
  localparam int B_LEFT  = 3;
  localparam int B_RIGHT = 4;

  localparam int F_START = 0;
  localparam int F_GRAV  = 1;
  localparam int F_DOWN  = 2;
  localparam int F_UP    = 3;
  localparam int F_LEFT  = 4;
  localparam int F_RIGHT = 5;

endpackage

// File: rtl/sc_movescheduler_buttonedge.sv
// sc_buttonedge: falling-edge press detector
// One register per button; press = was released, now pressed
module sc_buttonedge (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] btn_n,
  output logic [4:0] press
);

  logic [4:0] prev;

  // remember last sampled level; released (1) after reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) prev <= '1;
    else     prev <= btn_n;
  end

  assign press = prev & ~btn_n;

endmodule

// File: rtl/sc_movescheduler.sv
// sc_movescheduler: move sequencer for the falling-point register
// FSM, pending flags, gravity timer and settle timer
module sc_movescheduler
  import sc_movescheduler_pkg::*;
#(
  parameter int unsigned FALL_TICKS = 25000000,
  parameter int unsigned SETTLE     = 2
) (
  input  logic       SC_MOVESCHEDULER_CLOCK_50,
  input  logic       SC_MOVESCHEDULER_RESET_InHigh,
  input  logic       SC_MOVESCHEDULER_startButton_InLow,
  input  logic       SC_MOVESCHEDULER_upButton_InLow,
  input  logic       SC_MOVESCHEDULER_downButton_InLow,
  input  logic       SC_MOVESCHEDULER_leftButton_InLow,
  input  logic       SC_MOVESCHEDULER_rightButton_InLow,
  input  logic       SC_MOVESCHEDULER_bottomsidecomparator_InLow,
  output logic       SC_MOVESCHEDULER_clear_OutLow,
  output logic       SC_MOVESCHEDULER_load0_OutLow,
  output logic       SC_MOVESCHEDULER_load1_OutLow,
  output logic [1:0] SC_MOVESCHEDULER_shiftselection_Out,
  output logic       SC_MOVESCHEDULER_running_OutHigh,
  output logic       SC_MOVESCHEDULER_landed_OutHigh
);

  localparam int CW = (FALL_TICKS > 1) ? $clog2(FALL_TICKS) : 1;
  localparam int SW = $clog2(SETTLE + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(FALL_TICKS - 1);
  localparam logic [SW-1:0] SET_LAST = SW'(SETTLE - 1);

  logic clk;
  logic rst;
  logic bottom;
  assign clk    = SC_MOVESCHEDULER_CLOCK_50;
  assign rst    = SC_MOVESCHEDULER_RESET_InHigh;
  assign bottom = SC_MOVESCHEDULER_bottomsidecomparator_InLow;

  state_t        state, state_n;
  cmd_t          cmd, cmd_n;
  logic [5:0]    flag, flag_set, flag_clr;
  logic [CW-1:0] grav_cnt;
  logic [SW-1:0] set_cnt;
  logic          landed, landed_n;
  logic          active, wrap;
  logic [4:0]    btn_n, press;

  assign btn_n = {SC_MOVESCHEDULER_rightButton_InLow,
                  SC_MOVESCHEDULER_leftButton_InLow,
                  SC_MOVESCHEDULER_downButton_InLow,
                  SC_MOVESCHEDULER_upButton_InLow,
                  SC_MOVESCHEDULER_startButton_InLow};

  sc_buttonedge u_edge (
    .clk   (clk),
    .rst   (rst),
    .btn_n (btn_n),
    .press (press)
  );

  assign active = state inside {S_RUN, S_ISSUE, S_SETTLE};
  assign wrap   = active && (grav_cnt == CNT_LAST);

  // presses latch only while running; gravity latches on wrap
  always_comb begin
    flag_set = '0;
    if (active) begin
      flag_set[F_START] = press[B_START];
      flag_set[F_DOWN]  = press[B_DOWN];
      flag_set[F_UP]    = press[B_UP];
      flag_set[F_LEFT]  = press[B_LEFT];
      flag_set[F_RIGHT] = press[B_RIGHT];
    end
    flag_set[F_GRAV] = wrap;
  end

  // next state, command latch, flag service and landed pulse
  always_comb begin
    state_n  = state;
    cmd_n    = cmd;
    landed_n = 1'b0;
    flag_clr = '0;
    unique case (state)
      S_IDLE: if (press[B_START]) state_n = S_INIT;
      S_INIT: state_n = S_RUN;
      S_RUN: begin
        cmd_n = CMD_NONE;
        if (flag[F_START]) begin
          flag_clr[F_START] = 1'b1;
          state_n = S_PAUSE;
        end else if (flag[F_GRAV]) begin
          flag_clr[F_GRAV] = 1'b1;
          if (!bottom) begin
            landed_n = 1'b1;
          end else begin
            cmd_n   = CMD_DOWN;
            state_n = S_ISSUE;
          end
        end else if (flag[F_DOWN]) begin
          flag_clr[F_DOWN] = 1'b1;
          if (bottom) begin
            cmd_n   = CMD_DOWN;
            state_n = S_ISSUE;
          end
        end else if (flag[F_UP]) begin
          flag_clr[F_UP] = 1'b1;
          cmd_n   = CMD_UP;
          state_n = S_ISSUE;
        end else if (flag[F_LEFT]) begin
          flag_clr[F_LEFT] = 1'b1;
          cmd_n   = CMD_LEFT;
          state_n = S_ISSUE;
        end else if (flag[F_RIGHT]) begin
          flag_clr[F_RIGHT] = 1'b1;
          cmd_n   = CMD_RIGHT;
          state_n = S_ISSUE;
        end
      end
      S_ISSUE:  state_n = S_SETTLE;
      S_SETTLE: if (set_cnt == SET_LAST) state_n = S_RUN;
      S_PAUSE:  if (press[B_START]) state_n = S_RUN;
      default:  state_n = S_IDLE;
    endcase
  end

  // FSM, command, flags and landed registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= S_IDLE;
      cmd    <= CMD_NONE;
      flag   <= '0;
      landed <= 1'b0;
    end else begin
      state  <= state_n;
      cmd    <= cmd_n;
      flag   <= (flag & ~flag_clr) | flag_set;
      landed <= landed_n;
    end
  end

  // gravity timer: runs while active, holds in pause, zero otherwise
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                   grav_cnt <= '0;
    else if (wrap)             grav_cnt <= '0;
    else if (active)           grav_cnt <= grav_cnt + CW'(1);
    else if (state != S_PAUSE) grav_cnt <= '0;
  end

  // settle timer counts cycles spent in SETTLE
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                    set_cnt <= '0;
    else if (state == S_SETTLE) set_cnt <= set_cnt + SW'(1);
    else                        set_cnt <= '0;
  end

  // strobes decoded from registered state and command
  always_comb begin
    SC_MOVESCHEDULER_clear_OutLow       = 1'b1;
    SC_MOVESCHEDULER_load0_OutLow       = 1'b1;
    SC_MOVESCHEDULER_load1_OutLow       = 1'b1;
    SC_MOVESCHEDULER_shiftselection_Out = SHIFT_HOLD;
    if (state == S_INIT) SC_MOVESCHEDULER_clear_OutLow = 1'b0;
    if (state == S_ISSUE) begin
      unique case (cmd)
        CMD_UP:    SC_MOVESCHEDULER_load0_OutLow = 1'b0;
        CMD_DOWN:  SC_MOVESCHEDULER_load1_OutLow = 1'b0;
        CMD_LEFT:  SC_MOVESCHEDULER_shiftselection_Out = SHIFT_LEFT;
        CMD_RIGHT: SC_MOVESCHEDULER_shiftselection_Out = SHIFT_RIGHT;
        default:   ;
      endcase
    end
  end

  assign SC_MOVESCHEDULER_running_OutHigh = active;
  assign SC_MOVESCHEDULER_landed_OutHigh  = landed;

endmodule

// File: tb/tb_sc_movescheduler.sv
// Directed bench for sc_movescheduler
// FALL_TICKS=8, SETTLE=2; outputs sampled on the falling edge
module tb_sc_movescheduler;

  logic       clk = 1'b0;
  logic       rst;
  logic       start_n, up_n, down_n, left_n, right_n;
  logic       bottom;
  logic       clear, load0, load1, running, landed;
  logic [1:0] shift;
  logic [6:0] outs;

  int checks = 0;
  int errors = 0;
  int n = 0;

  // {clear, load0, load1, shift[1:0], running, landed}
  localparam logic [6:0] IDLE_OFF = 7'b1111100;
  localparam logic [6:0] RUN_IDLE = 7'b1111110;
  localparam logic [6:0] CLR      = 7'b0111100;
  localparam logic [6:0] LOAD0    = 7'b1011110;
  localparam logic [6:0] LOAD1    = 7'b1101110;
  localparam logic [6:0] LEFT     = 7'b1110110;
  localparam logic [6:0] RIGHT    = 7'b1111010;
  localparam logic [6:0] LANDED   = 7'b1111111;

  always #5 clk = ~clk;

  assign outs = {clear, load0, load1, shift, running, landed};

  sc_movescheduler #(.FALL_TICKS(8), .SETTLE(2)) dut (
    .SC_MOVESCHEDULER_CLOCK_50                  (clk),
    .SC_MOVESCHEDULER_RESET_InHigh              (rst),
    .SC_MOVESCHEDULER_startButton_InLow         (start_n),
    .SC_MOVESCHEDULER_upButton_InLow            (up_n),
    .SC_MOVESCHEDULER_downButton_InLow          (down_n),
    .SC_MOVESCHEDULER_leftButton_InLow          (left_n),
    .SC_MOVESCHEDULER_rightButton_InLow         (right_n),
    .SC_MOVESCHEDULER_bottomsidecomparator_InLow(bottom),
    .SC_MOVESCHEDULER_clear_OutLow              (clear),
    .SC_MOVESCHEDULER_load0_OutLow              (load0),
    .SC_MOVESCHEDULER_load1_OutLow              (load1),
    .SC_MOVESCHEDULER_shiftselection_Out        (shift),
    .SC_MOVESCHEDULER_running_OutHigh           (running),
    .SC_MOVESCHEDULER_landed_OutHigh            (landed)
  );

  task automatic chk(input string tag, input logic [6:0] obs,
                     input logic [6:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    n++;
  endtask

  // reset, press start, land in RUN at relative cycle 2
  task automatic boot(input logic bot);
    rst = 1'b1;
    bottom = bot;
    {start_n, up_n, down_n, left_n, right_n} = '1;
    @(negedge clk);
    chk("reset_idle", outs, IDLE_OFF);
    rst = 1'b0;
    start_n = 1'b0;
    @(negedge clk);
    chk("init_clear", outs, CLR);
    start_n = 1'b1;
    @(negedge clk);
    chk("boot_run", outs, RUN_IDLE);
    n = 2;
  endtask

  initial begin
    // start sequence; then up held 20 cycles: one load0, gravity at 11,19
    boot(1'b1);
    up_n = 1'b0;
    while (n < 22) begin
      step();
      chk("up_held", outs,
          (n == 4) ? LOAD0 :
          (n == 11 || n == 19) ? LOAD1 : RUN_IDLE);
    end
    up_n = 1'b1;

    // left and right together: left first, right 4 cycles later
    boot(1'b1);
    left_n  = 1'b0;
    right_n = 1'b0;
    while (n < 9) begin
      step();
      chk("left_right", outs,
          (n == 4) ? LEFT : (n == 8) ? RIGHT : RUN_IDLE);
      if (n == 4) begin
        left_n  = 1'b1;
        right_n = 1'b1;
      end
    end

    // at bottom: down discarded, landed on each wrap, no load1
    boot(1'b0);
    down_n = 1'b0;
    while (n < 26) begin
      step();
      chk("bottom_land", outs,
          (n == 11 || n == 19) ? LANDED : RUN_IDLE);
      if (n == 4) down_n = 1'b1;
    end
    // off bottom: pending wrap becomes load1, then every 8 cycles
    bottom = 1'b1;
    while (n < 43) begin
      step();
      chk("grav_load1", outs,
          (n == 27 || n == 35 || n == 43) ? LOAD1 : RUN_IDLE);
    end

    // pause with counter at 5 on the start press, resume after 30
    boot(1'b1);
    while (n < 42) begin
      step();
      chk("pause", outs,
          (n >= 9 && n <= 38) ? IDLE_OFF :
          (n == 41) ? LOAD1 : RUN_IDLE);
      if (n == 7 || n == 38) start_n = 1'b0;
      if (n == 8 || n == 39) start_n = 1'b1;
    end

    // reset in the middle of a load1 strobe
    boot(1'b1);
    down_n = 1'b0;
    step();
    chk("down_wait", outs, RUN_IDLE);
    step();
    chk("down_issue", outs, LOAD1);
    #2 rst = 1'b1;
    #1 chk("async_reset", outs, IDLE_OFF);
    @(negedge clk);
    rst = 1'b0;
    down_n = 1'b1;
    @(negedge clk);
    chk("post_reset", outs, IDLE_OFF);
    down_n = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      chk("idle_down", outs, IDLE_OFF);
    end
    down_n = 1'b1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sc_movescheduler.md
# sc_movescheduler

Sequencing controller for the falling-point register. It arbitrates between player button presses and an internal gravity timer, and issues at most one move command per settle window. Commands go out as the register's clear, load and shift controls. It sits between the debounced buttons and the point register/comparator pair, and adds start/pause control, blocked-move filtering and a landed indication.

## Interface
Parameters:
- FALL_TICKS, 25000000: clock cycles between gravity down-moves (0.5 s at 50 MHz); counter width is $clog2(FALL_TICKS).
- SETTLE, 2: idle cycles after each command so the register and comparator outputs update; minimum 1.

Ports:
- SC_MOVESCHEDULER_CLOCK_50, in, 1: system clock.
- SC_MOVESCHEDULER_RESET_InHigh, in, 1: asynchronous, active-high reset.
- SC_MOVESCHEDULER_startButton_InLow, upButton_InLow, downButton_InLow, leftButton_InLow, rightButton_InLow, in, 1 each: debounced buttons, pressed = 0.
- SC_MOVESCHEDULER_bottomsidecomparator_InLow, in, 1: 0 = point at bottom, down blocked.
- SC_MOVESCHEDULER_clear_OutLow, out, 1: register clear strobe.
- SC_MOVESCHEDULER_load0_OutLow, out, 1: up-load strobe.
- SC_MOVESCHEDULER_load1_OutLow, out, 1: down-load strobe.
- SC_MOVESCHEDULER_shiftselection_Out, out, 2: 11 hold, 01 left, 10 right.
- SC_MOVESCHEDULER_running_OutHigh, out, 1: high in RUN/ISSUE/SETTLE.
- SC_MOVESCHEDULER_landed_OutHigh, out, 1: one-cycle pulse when gravity fires at bottom.

## Operation
- States: IDLE, INIT, RUN, ISSUE, SETTLE, PAUSE.
- Outputs are decoded from the registered state plus a registered command code.
- Press detection: each button is registered once. A press is previous = 1 and current = 0, so holding a button gives one press.
- Pending flags: start, grav, down, up, left, right.
  - A flag is set on press, or on gravity wrap for grav.
  - A flag is cleared when it is served or discarded.
  - Set and clear in the same cycle: set wins.
- Gravity counter:
  - Counts only in RUN/ISSUE/SETTLE and holds in PAUSE.
  - Zeroed in IDLE and INIT.
  - At FALL_TICKS-1 it wraps to 0 and sets grav. A wrap while grav is already set merges into it.
- IDLE: all presses except start are ignored. Start goes to INIT.
- INIT: clear_OutLow = 0 for one cycle, then RUN.
- RUN: serve by priority start > grav > down > up > left > right.
  - start: clear the flag and go to PAUSE.
  - grav or down with bottom = 0: discard the flag and stay in RUN. Grav additionally pulses landed for one cycle.
  - Any other served flag: latch its command and go to ISSUE.
  - Nothing pending: stay in RUN.
- ISSUE: one-cycle strobe of the latched command, then SETTLE.
  - up: load0 = 0.
  - down/grav: load1 = 0.
  - left: shift = 01.
  - right: shift = 10.
- SETTLE: SETTLE cycles with idle outputs, then RUN. Presses and wraps still latch.
- PAUSE: start goes to RUN. Other presses are not latched. Already-pending flags are kept.
- Idle output values: clear = 1, load0 = 1, load1 = 1, shift = 11.

## Timing
- Reset, asynchronous and at any time including mid-ISSUE: state IDLE, counter 0, all flags 0. Outputs go immediately to idle values with running = 0 and landed = 0.
- Press latency: press detected at edge n, strobe during cycle n+1..n+2 when in RUN at edge n. The next command can strobe no earlier than 2+SETTLE cycles later.
- Exactly one strobe per ISSUE. Never two strobe types at once. Never a strobe outside ISSUE/INIT.
- Gravity period: FALL_TICKS cycles of RUN/ISSUE/SETTLE time. A pending grav delays lower-priority presses.
- The bottom comparator is sampled only in RUN at decision time.

## Structure
- Shared package sc_movescheduler_pkg holds:
  - State localparams.
  - Shift codes SHIFT_HOLD = 2'b11, SHIFT_LEFT = 2'b01, SHIFT_RIGHT = 2'b10.
  - Command codes CMD_NONE/UP/DOWN/LEFT/RIGHT.
- Sub-module sc_buttonedge: 5-bit registered falling-edge detector producing one-cycle press pulses. One instance.
- The top level holds the FSM, pending flags, gravity counter and settle counter.

## Test plan
All scenarios use FALL_TICKS = 8 and SETTLE = 2.
- Reset, then start pressed: clear low exactly 1 cycle, running = 1 from the next cycle. All other outputs idle throughout.
- In RUN, up held for 20 cycles: exactly one load0 low pulse, 1 cycle after detection. No repeat while held.
- In RUN, left and right pressed on the same edge: shift = 01 for one cycle, then after 2 settle cycles shift = 10 for one cycle.
- Bottom = 0, down pressed, gravity wraps: no load1 pulse ever, one landed pulse per wrap (every 8 running cycles). With bottom = 1, load1 pulses every 8 cycles.
- Start pressed in RUN with counter at 5, wait 30 cycles in PAUSE, start again: no strobes during PAUSE. The first gravity load1 comes 3 running cycles after resume.
- Reset asserted during an ISSUE load1 strobe: load1 returns to 1 with no clock edge. State IDLE, and a later down press yields no strobe.
